// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage core.
// It also sequences Execute occupancy for multi-cycle multiplies.
// Build option HAZARD_FWD_EN: when defined, E operands are forwarded from M/W and only
// load-use stalls. When undefined, fwd_* stay 00 and any RAW hazard in flight stalls Decode.
module hazard_unit #(
   parameter int unsigned REGW    = 4,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [REGW-1:0] rs1_d,
   input  logic [REGW-1:0] rs2_d,
   input  logic [REGW-1:0] rs1_e,
   input  logic [REGW-1:0] rs2_e,
   input  logic [REGW-1:0] rd_e,
   input  logic [REGW-1:0] rd_m,
   input  logic [REGW-1:0] rd_w,
   input  logic            regwrite_e,
   input  logic            regwrite_m,
   input  logic            regwrite_w,
   input  logic            memtoreg_e,
   input  logic            mul_start_e,
   input  logic            branch_taken_e,
   output logic            stall_f,
   output logic            stall_d,
   output logic            stall_e,
   output logic            flush_d,
   output logic            flush_e,
   output logic            flush_m,
   output logic [1:0]      fwd_a_e,
   output logic [1:0]      fwd_b_e,
   output logic            mul_busy,
   output logic [15:0]     stall_cycles
);

   localparam int unsigned CNTW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
   localparam bit          MulEn = (MUL_LAT >= 2);
   // First MUL cycle stalls while cnt counts MUL_LAT-2 down to 0; the cnt==0 cycle releases E.
   localparam logic [CNTW-1:0] CntInit = CNTW'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

   typedef enum logic {StRun, StMul} state_e;

   state_e          state_q;
   logic [CNTW-1:0] cnt_q;
   logic [15:0]     stall_cycles_q;

   logic       mul_go;
   logic       mul_stall;
   logic       data_stall;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // Nonzero destination with write enable matching either Decode source.
   function automatic logic dep(input logic [REGW-1:0] rd, input logic we,
                                input logic [REGW-1:0] a, input logic [REGW-1:0] b);
      return we && (rd != '0) && ((rd == a) || (rd == b));
   endfunction

   // Operand source for one E operand; M is the younger producer and wins over W.
   function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] rs,
                                          input logic [REGW-1:0] rdm, input logic wem,
                                          input logic [REGW-1:0] rdw, input logic wew);
      if (wem && (rdm != '0) && (rdm == rs)) return 2'b10;
      if (wew && (rdw != '0) && (rdw == rs)) return 2'b01;
      return 2'b00;
   endfunction

   // Hazard detection: multiply occupancy, data dependencies and forwarding selects.
   always_comb begin
      mul_go    = MulEn && mul_start_e;
      mul_stall = (state_q == StRun) ? mul_go : (cnt_q != '0);
`ifdef HAZARD_FWD_EN
      data_stall = memtoreg_e && dep(rd_e, regwrite_e, rs1_d, rs2_d);
      fwd_a      = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
      fwd_b      = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
`else
      // Without forwarding every in-flight producer blocks Decode; load-use is a subset.
      data_stall = dep(rd_e, regwrite_e, rs1_d, rs2_d) ||
                   dep(rd_m, regwrite_m, rs1_d, rs2_d) ||
                   dep(rd_w, regwrite_w, rs1_d, rs2_d);
      fwd_a      = 2'b00;
      fwd_b      = 2'b00;
`endif
   end

`ifndef HAZARD_FWD_EN
   // E sources and the load flag only matter for forwarding.
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{rs1_e, rs2_e, memtoreg_e};
`endif

   // Output decode with multiply > branch > data-stall priority; everything low in reset.
   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_m  = 1'b0;
      fwd_a_e  = 2'b00;
      fwd_b_e  = 2'b00;
      mul_busy = 1'b0;
      if (reset_n) begin
         fwd_a_e  = fwd_a;
         fwd_b_e  = fwd_b;
         mul_busy = (state_q == StMul);
         if (mul_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
         end else if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (data_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // Multiply occupancy FSM and its down-counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (mul_go) begin
                  state_q <= StMul;
                  cnt_q   <= CntInit;
               end
            end
            StMul: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNTW'(1);
               end else begin
                  state_q <= StRun;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   // Saturating count of Decode stall cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles_q <= '0;
      end else if (stall_d && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_q <= stall_cycles_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver pushes model predictions per cycle,
// the monitor pops and compares them on the falling edge.
module tb_hazard_unit;
   localparam int unsigned REGW    = 4;
   localparam int unsigned MUL_LAT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_n = 1'b0;
   logic [REGW-1:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
   logic [REGW-1:0] rd_e = '0, rd_m = '0, rd_w = '0;
   logic            regwrite_e = 1'b0, regwrite_m = 1'b0, regwrite_w = 1'b0;
   logic            memtoreg_e = 1'b0, mul_start_e = 1'b0, branch_taken_e = 1'b0;
   logic            stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mul_busy;
   logic [1:0]      fwd_a_e, fwd_b_e;
   logic [15:0]     stall_cycles;

   hazard_unit #(.REGW(REGW), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
      .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
      .memtoreg_e(memtoreg_e), .mul_start_e(mul_start_e), .branch_taken_e(branch_taken_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mul_busy(mul_busy), .stall_cycles(stall_cycles)
   );

   typedef struct packed {
      logic [REGW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
      logic            regwrite_e, regwrite_m, regwrite_w, memtoreg_e, mul_start_e, branch_taken_e;
   } stim_t;

   typedef struct packed {
      logic        sf, sd, se, fd, fe, fm;
      logic [1:0]  fa, fb;
      logic        busy;
      logic [15:0] sc;
   } resp_t;

   typedef struct {
      resp_t exp;
      int    cyc;
   } item_t;

   item_t sb[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;
   // Reference state: cycles the current multiply has spent in E (0 = none), stall count.
   int    occ      = 0;
   int    sc_model = 0;

   function automatic bit reads(input logic [REGW-1:0] rd, input logic we, input stim_t s);
      return we && (rd != 0) && (rd == s.rs1_d || rd == s.rs2_d);
   endfunction

   function automatic logic [1:0] src(input logic [REGW-1:0] rs, input stim_t s);
      if (s.regwrite_m && s.rd_m != 0 && s.rd_m == rs) return 2'b10;
      if (s.regwrite_w && s.rd_w != 0 && s.rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Drive one cycle of inputs, predict the outputs for that cycle and queue them.
   task automatic apply(input stim_t s, input logic rst_n_v);
      resp_t e;
      item_t it;
      int    occ_now;
      bit    mstall, dstall;
      @(posedge clk);
      #1;
      reset_n = rst_n_v;
      rs1_d = s.rs1_d; rs2_d = s.rs2_d; rs1_e = s.rs1_e; rs2_e = s.rs2_e;
      rd_e = s.rd_e; rd_m = s.rd_m; rd_w = s.rd_w;
      regwrite_e = s.regwrite_e; regwrite_m = s.regwrite_m; regwrite_w = s.regwrite_w;
      memtoreg_e = s.memtoreg_e; mul_start_e = s.mul_start_e;
      branch_taken_e = s.branch_taken_e;
      e = '0;
      if (!rst_n_v) begin
         occ      = 0;
         sc_model = 0;
      end else begin
         if (occ > 0) occ_now = occ + 1;
         else occ_now = (s.mul_start_e && MUL_LAT >= 2) ? 1 : 0;
         // The op occupies E for MUL_LAT cycles; all but the last one stall.
         mstall = (occ_now >= 1) && (occ_now < MUL_LAT);
         e.busy = (occ_now >= 2);
         e.sc   = 16'(sc_model);
`ifdef HAZARD_FWD_EN
         dstall = s.memtoreg_e && reads(s.rd_e, s.regwrite_e, s);
         e.fa   = src(s.rs1_e, s);
         e.fb   = src(s.rs2_e, s);
`else
         dstall = reads(s.rd_e, s.regwrite_e, s) || reads(s.rd_m, s.regwrite_m, s) ||
                  reads(s.rd_w, s.regwrite_w, s);
`endif
         if (mstall) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.fm = 1;
         end else if (s.branch_taken_e) begin
            e.fd = 1; e.fe = 1;
         end else if (dstall) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
         end
         if (e.sd && sc_model < 65535) sc_model++;
         occ = (occ_now == MUL_LAT) ? 0 : occ_now;
      end
      it.exp = e;
      it.cyc = cyc;
      sb.push_back(it);
      cyc++;
   endtask

   // Monitor: outputs are valid every cycle, compare on the falling edge.
   always @(negedge clk) begin
      item_t it;
      resp_t act;
      if (sb.size() > 0) begin
         it  = sb.pop_front();
         act = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, fwd_a_e, fwd_b_e,
                mul_busy, stall_cycles};
         checks++;
         if (act !== it.exp) begin
            errors++;
            $display("FAIL cycle %0d {sf,sd,se,fd,fe,fm,fwa,fwb,busy}: got %b want %b, stall_cycles got %0d want %0d",
                     it.cyc, act[26:16], it.exp[26:16], act.sc, it.exp.sc);
         end
      end
   end

   initial begin
      stim_t s;
      // Reset with a load-use pattern present, then release.
      s = '0; s.rd_e = 3; s.rs1_d = 3; s.memtoreg_e = 1; s.regwrite_e = 1;
      apply(s, 0);
      apply(s, 0);
      apply(s, 1);
      s = '0;
      apply(s, 1);
      // Forwarding: M over W, then register 0 never forwards.
      s = '0; s.rd_m = 5; s.rd_w = 5; s.regwrite_m = 1; s.regwrite_w = 1; s.rs1_e = 5;
      apply(s, 1);
      s.rd_m = 6; s.rs2_e = 6;
      apply(s, 1);
      s = '0; s.regwrite_e = 1; s.regwrite_m = 1; s.regwrite_w = 1;
      apply(s, 1);
      // Multiply held in E for its full latency.
      s = '0; s.mul_start_e = 1;
      repeat (MUL_LAT) apply(s, 1);
      s = '0;
      repeat (2) apply(s, 1);
      // Back-to-back multiplies.
      s.mul_start_e = 1;
      repeat (2 * MUL_LAT) apply(s, 1);
      s = '0;
      apply(s, 1);
      // Taken branch with a coincident load-use.
      s = '0; s.memtoreg_e = 1; s.regwrite_e = 1; s.rd_e = 2; s.rs2_d = 2; s.branch_taken_e = 1;
      apply(s, 1);
      s.branch_taken_e = 0;
      apply(s, 1);
      // Reset pulse mid-multiply with cnt at 1.
      s = '0; s.mul_start_e = 1;
      apply(s, 1);
      apply(s, 1);
      apply(s, 0);
      s = '0;
      repeat (2) apply(s, 1);
      // RAW against M, then W, then retired.
      s = '0; s.rd_m = 7; s.regwrite_m = 1; s.rs2_d = 7;
      repeat (2) apply(s, 1);
      s.rd_m = 0; s.regwrite_m = 0; s.rd_w = 7; s.regwrite_w = 1;
      apply(s, 1);
      s = '0; s.rs2_d = 7;
      apply(s, 1);
      // Random traffic with occasional reset pulses.
      for (int i = 0; i < 3000; i++) begin
         s.rs1_d = 4'($urandom_range(0, 3));
         s.rs2_d = 4'($urandom_range(0, 3));
         s.rs1_e = 4'($urandom_range(0, 3));
         s.rs2_e = 4'($urandom_range(0, 3));
         s.rd_e  = 4'($urandom_range(0, 5));
         s.rd_m  = 4'($urandom_range(0, 5));
         s.rd_w  = 4'($urandom_range(0, 5));
         s.regwrite_e     = 1'($urandom_range(0, 1));
         s.regwrite_m     = 1'($urandom_range(0, 1));
         s.regwrite_w     = 1'($urandom_range(0, 1));
         s.memtoreg_e     = 1'($urandom_range(0, 1));
         s.mul_start_e    = ($urandom_range(0, 7) == 0);
         s.branch_taken_e = ($urandom_range(0, 5) == 0);
         apply(s, ($urandom_range(0, 99) != 0));
      end
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage core. It drives the `hazard_detected` hold input of the F/D/E pipeline flops and their flush controls. It also selects operand forwarding into Execute and sequences multi-cycle multiply occupancy of Execute. It sits beside the pipeline registers and is the only source of stall and flush controls in the datapath.

## Interface
- `REGW`, 4: register index width; index 0 is hardwired zero and never hazards.
- `MUL_LAT`, 4: Execute occupancy in cycles of a multi-cycle op; must be >= 1.
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `rs1_d`, `rs2_d`  in  REGW  source registers of the instruction in Decode.
- `rs1_e`, `rs2_e`  in  REGW  source registers of the instruction in Execute.
- `rd_e`, `rd_m`, `rd_w`  in  REGW  destination registers in E/M/W.
- `regwrite_e`, `regwrite_m`, `regwrite_w`  in  1  destination write enable per stage.
- `memtoreg_e`  in  1  instruction in E is a load.
- `mul_start_e`  in  1  instruction in E is a multi-cycle op.
- `branch_taken_e`  in  1  branch in E resolved taken.
- `stall_f`, `stall_d`, `stall_e`  out  1  hold the F, D and E registers.
- `flush_d`, `flush_e`, `flush_m`  out  1  load a bubble into the D, E and M registers.
- `fwd_a_e`, `fwd_b_e`  out  2  operand source: 00 regfile, 10 from M, 01 from W.
- `mul_busy`  out  1  FSM is in state MUL.
- `stall_cycles`  out  16  saturating count of cycles with `stall_d`=1.

## Operation
- FSM has two states, RUN and MUL, plus a down-counter `cnt` of width clog2(MUL_LAT).
- Multiply, RUN:
  - If `mul_start_e`=1 and MUL_LAT>=2: assert `stall_f`, `stall_d`, `stall_e` and `flush_m`; load `cnt`<=MUL_LAT-2; go to MUL.
  - If MUL_LAT=1: `mul_start_e` is ignored.
- Multiply, MUL:
  - If `cnt`!=0: stall_f/d/e=1, flush_m=1, `cnt` decrements.
  - If `cnt`==0: no multiply stall; next state is RUN.
  - Result: E holds the op exactly MUL_LAT cycles.
- Branch:
  - Applies when `branch_taken_e`=1 and no multiply stall.
  - Assert `flush_d`=1 and `flush_e`=1; no stall.
  - Ignored while `stall_e`=1.
- Load-use:
  - Condition: `memtoreg_e` & `regwrite_e` & `rd_e`!=0 & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
  - Response: `stall_f`=`stall_d`=1 and `flush_e`=1, for one bubble.
- Priority: multiply stall > branch > load-use. A taken branch coinciding with load-use flushes and does not stall.
- Forwarding, per operand (A uses `rs1_e`, B uses `rs2_e`):
  - 10 if `regwrite_m` & `rd_m`!=0 & `rd_m`==rs.
  - Else 01 if `regwrite_w` & `rd_w`!=0 & `rd_w`==rs.
  - Else 00.
  - M has priority over W.
- `stall_cycles` increments each cycle `stall_d`=1 and saturates at 16'hFFFF.

## Timing
- Stall, flush, forward and `mul_busy` outputs are combinational from inputs and state, valid in the same cycle. The pipeline flops sample them at the next rising edge.
- Registered state is FSM, `cnt` and `stall_cycles`.
- Reset, while `reset_n`=0:
  - Registered state: FSM=RUN, `cnt`=0, `stall_cycles`=0.
  - All outputs forced to 0, including `fwd_*`=00.
- Reset asserted mid-MUL aborts to RUN with no residual stall after release.
- Back-to-back multiplies: the second `mul_start_e` is seen in RUN after the exit cycle and starts a new sequence.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above.
- `HAZARD_FWD_EN` undefined:
  - `fwd_a_e`/`fwd_b_e` tied to 00.
  - Any RAW between `rs1_d`/`rs2_d` and a nonzero `rd_e`/`rd_m`/`rd_w` with its `regwrite` set stalls F/D and flushes E, until no match remains.
  - The load-use rule is subsumed by this stall.
  - Priority is unchanged.

## Test plan
- Reset with inputs active: `rd_e`=3, `rs1_d`=3, `memtoreg_e`=1 -> all outputs 0. After release: `stall_d`=1, `flush_e`=1 for one cycle, then `stall_cycles`=1.
- `rd_m`=5 and `rd_w`=5, both with regwrite, `rs1_e`=5 -> `fwd_a_e`=10. Same with `rd_e`, `rd_m`, `rd_w`=0 and `rs1_e`=0 -> 00.
- MUL_LAT=4, `mul_start_e` held while stalled -> stall_f/d/e high 3 cycles, `mul_busy` high 3 cycles, E released on the 4th edge.
- `branch_taken_e`=1 with a simultaneous load-use match -> `flush_d`=`flush_e`=1, `stall_d`=0.
- `reset_n` pulsed low in MUL with `cnt`=1 -> FSM RUN, `mul_busy`=0, no stall after release.
- `HAZARD_FWD_EN` undefined, `rd_m`=7, `regwrite_m`=1, `rs2_d`=7 -> `stall_d`=1 and `flush_e`=1 until `rd_w` retires, then 0.
